msp430_alu_mpseq: RTL and testbench

Multi-precision arithmetic sequencer that drives one `msp430_alu` instance to run ADD, SUB, DADD and CMP over operands of 1 to 8 words. It chains the carry between words and returns each result word and the aggregate {V,N,Z,C} flags. It sits between a command source (debug unit or memory-mapped accelerator front end) and a dedicated ALU instance. That ALU instance ties `inst_bw`, `inst_jmp`, `inst_so` and `dbg_halt_st` to 0.

---
 rtl/msp430_alu_mpseq.sv | 170 +++++++++++++++++
 tb/tb_msp430_alu_mpseq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msp430_alu_mpseq.sv
// Multi-word ADD/SUB/DADD/CMP sequencer that drives a dedicated msp430_alu instance.
// It sends one operand pair per word (LS first), chains carry through alu_status[0] and folds the flags.
module msp430_alu_mpseq (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_len,
  input  logic        abort,
  input  logic        opnd_valid,
  output logic        opnd_ready,
  input  logic [15:0] opnd_src,
  input  logic [15:0] opnd_dst,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_last,
  output logic        done,
  output logic [3:0]  done_stat,
  output logic        busy,
  output logic [15:0] alu_op_src,
  output logic [15:0] alu_op_dst,
  output logic        alu_exec_cycle,
  output logic [11:0] alu_inst_alu,
  output logic [3:0]  alu_status,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_stat
);
  localparam int ALU_SRC_INV = 0;
  localparam int ALU_INC_C   = 2;
  localparam int ALU_ADD     = 3;
  localparam int ALU_DADD    = 7;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_DADD = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_op;
  logic [2:0]  r_len;
  logic [2:0]  r_wcnt;
  logic        r_carry;
  logic        r_zacc;
  logic        r_v;
  logic        r_n;
  logic [15:0] r_res_data;
  logic [15:0] r_op_src;
  logic [15:0] r_op_dst;
  logic [3:0]  r_done_stat;

  logic w_last;
  logic w_abort;
  logic w_is_cmp;
  logic w_opnd_hs;
  logic w_res_hs;

  assign w_last    = (r_wcnt == r_len);
  assign w_abort   = abort && (r_state != S_IDLE);
  assign w_is_cmp  = (r_op == OP_CMP);
  assign w_opnd_hs = opnd_valid && opnd_ready;
  assign w_res_hs  = res_valid && res_ready;

  assign res_data   = r_res_data;
  assign done_stat  = r_done_stat;
  assign alu_op_src = r_op_src;
  assign alu_op_dst = r_op_dst;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = S_FETCH;
      S_FETCH: if (w_opnd_hs) w_state_next = S_EXEC;
      S_EXEC: begin
        if (!w_is_cmp)   w_state_next = S_OUT;
        else if (w_last) w_state_next = S_DONE;
        else             w_state_next = S_FETCH;
      end
      S_OUT:   if (w_res_hs) w_state_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_abort) w_state_next = S_IDLE;
  end

  // Handshake outputs drop combinationally on abort so a coincident transfer never completes.
  always_comb begin
    cmd_ready      = (r_state == S_IDLE);
    busy           = (r_state != S_IDLE);
    opnd_ready     = (r_state == S_FETCH) && !abort;
    res_valid      = (r_state == S_OUT) && !abort;
    res_last       = (r_state == S_OUT) && !abort && w_last;
    done           = (r_state == S_DONE);
    alu_exec_cycle = (r_state == S_EXEC);
    alu_status     = {3'b000, (r_state == S_EXEC) && r_carry};
    alu_inst_alu   = 12'h000;
    if (r_state == S_EXEC) begin
      case (r_op)
        OP_ADD: begin
          alu_inst_alu[ALU_ADD]   = 1'b1;
          alu_inst_alu[ALU_INC_C] = 1'b1;
        end
        OP_DADD: alu_inst_alu[ALU_DADD] = 1'b1;
        default: begin
          alu_inst_alu[ALU_SRC_INV] = 1'b1;
          alu_inst_alu[ALU_ADD]     = 1'b1;
          alu_inst_alu[ALU_INC_C]   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_len       <= 3'd0;
      r_wcnt      <= 3'd0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_v         <= 1'b0;
      r_n         <= 1'b0;
      r_res_data  <= 16'h0000;
      r_op_src    <= 16'h0000;
      r_op_dst    <= 16'h0000;
      r_done_stat <= 4'h0;
    end else begin
      r_state <= w_state_next;
      if (!w_abort) begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid) begin
              r_op    <= cmd_op;
              r_len   <= cmd_len;
              r_wcnt  <= 3'd0;
              // SUB/CMP compute dst + ~src + 1, so the chain starts with carry set.
              r_carry <= (cmd_op == OP_SUB) || (cmd_op == OP_CMP);
              r_zacc  <= 1'b1;
              r_v     <= 1'b0;
              r_n     <= 1'b0;
            end
          end
          S_FETCH: begin
            if (w_opnd_hs) begin
              r_op_src <= opnd_src;
              r_op_dst <= opnd_dst;
            end
          end
          S_EXEC: begin
            r_res_data <= alu_out;
            r_carry    <= alu_stat[0];
            r_zacc     <= r_zacc & alu_stat[1];
            r_n        <= alu_stat[2];
            r_v        <= alu_stat[3];
            if (w_is_cmp && !w_last) r_wcnt <= r_wcnt + 3'd1;
          end
          S_OUT: begin
            if (w_res_hs && !w_last) r_wcnt <= r_wcnt + 3'd1;
          end
          S_DONE: r_done_stat <= {r_v, r_n, r_zacc, r_carry};
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_msp430_alu_mpseq.sv
// Bench for msp430_alu_mpseq: behavioural ALU stand-in plus a wide-integer reference model,
// directed cases from the plan followed by random multi-word commands.
module tb_msp430_alu_mpseq;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_DADD = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;
  localparam int B_SRC_INV = 0;
  localparam int B_INC_C   = 2;
  localparam int B_ADD     = 3;
  localparam int B_DADD    = 7;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_len = 3'd0;
  logic        abort = 1'b0;
  logic        opnd_valid = 1'b0;
  logic        opnd_ready;
  logic [15:0] opnd_src = 16'h0;
  logic [15:0] opnd_dst = 16'h0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_last;
  logic        done;
  logic [3:0]  done_stat;
  logic        busy;
  logic [15:0] alu_op_src;
  logic [15:0] alu_op_dst;
  logic        alu_exec_cycle;
  logic [11:0] alu_inst_alu;
  logic [3:0]  alu_status;
  logic [15:0] alu_out;
  logic [3:0]  alu_stat;

  int total = 0;
  int bad   = 0;

  logic [15:0] g_src [8];
  logic [15:0] g_dst [8];
  logic [15:0] exp_res [8];
  logic [3:0]  exp_stat;

  always #5 mclk = ~mclk;

  msp430_alu_mpseq dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .abort(abort),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_src(opnd_src), .opnd_dst(opnd_dst),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .done(done), .done_stat(done_stat), .busy(busy),
    .alu_op_src(alu_op_src), .alu_op_dst(alu_op_dst), .alu_exec_cycle(alu_exec_cycle),
    .alu_inst_alu(alu_inst_alu), .alu_status(alu_status),
    .alu_out(alu_out), .alu_stat(alu_stat)
  );

  // Stand-in for the msp430_alu: single-word add (with optional inversion / carry-in) or BCD add.
  logic [15:0] m_sx;
  logic [15:0] m_res;
  logic [16:0] m_sum;
  logic [4:0]  m_dig;
  logic        m_c;
  logic        m_v;
  always_comb begin
    m_sx  = alu_inst_alu[B_SRC_INV] ? ~alu_op_src : alu_op_src;
    m_c   = alu_status[0];
    m_res = 16'h0000;
    m_sum = 17'h0;
    m_dig = 5'h0;
    m_v   = 1'b0;
    if (alu_inst_alu[B_DADD]) begin
      for (int d = 0; d < 4; d++) begin
        m_dig = {1'b0, alu_op_dst[4*d +: 4]} + {1'b0, alu_op_src[4*d +: 4]} + {4'b0000, m_c};
        if (m_dig > 5'd9) begin
          m_dig = m_dig - 5'd10;
          m_c   = 1'b1;
        end else begin
          m_c = 1'b0;
        end
        m_res[4*d +: 4] = m_dig[3:0];
      end
    end else if (alu_inst_alu[B_ADD]) begin
      m_sum = {1'b0, alu_op_dst} + {1'b0, m_sx} + {16'h0000, alu_inst_alu[B_INC_C] & alu_status[0]};
      m_res = m_sum[15:0];
      m_c   = m_sum[16];
      m_v   = (alu_op_dst[15] == m_sx[15]) && (m_res[15] != alu_op_dst[15]);
    end else begin
      m_c = 1'b0;
    end
    alu_out  = m_res;
    alu_stat = {m_v, m_res[15], (m_res == 16'h0000), m_c};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Whole-number reference: operands as 16n-bit binary or 4n-digit decimal values.
  task automatic ref_model(input logic [1:0] op, input int n);
    logic [128:0] a, b, r, s, pw, mask, dg;
    logic [15:0]  wd, ws;
    logic         c, v, sa, sb, sr;
    int           bits;
    bits = 16 * n;
    a = '0; b = '0; r = '0; v = 1'b0;
    if (op == OP_DADD) begin
      pw = 129'd1;
      for (int i = 4*n - 1; i >= 0; i--) begin
        wd = g_dst[i/4];
        ws = g_src[i/4];
        a  = a * 129'd10 + 129'((wd >> (4*(i%4))) & 16'h000F);
        b  = b * 129'd10 + 129'((ws >> (4*(i%4))) & 16'h000F);
        pw = pw * 129'd10;
      end
      s = a + b;
      c = (s >= pw);
      if (c) s = s - pw;
      for (int i = 0; i < 4*n; i++) begin
        dg = s % 129'd10;
        s  = s / 129'd10;
        r  = r | (dg << (4*i));
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        a = a | (129'(g_dst[i]) << (16*i));
        b = b | (129'(g_src[i]) << (16*i));
      end
      mask = (129'd1 << bits) - 129'd1;
      sa = a[bits-1];
      sb = b[bits-1];
      if (op == OP_ADD) begin
        s = a + b;
        c = s[bits];
        r = s & mask;
        sr = r[bits-1];
        v = (sa == sb) && (sr != sa);
      end else begin
        r = (a - b) & mask;
        c = (a >= b);
        sr = r[bits-1];
        v = (sa != sb) && (sr != sa);
      end
    end
    for (int i = 0; i < 8; i++) exp_res[i] = (i < n) ? r[16*i +: 16] : 16'h0000;
    exp_stat = {v, r[bits-1], (r == 129'd0), c};
  endtask

  // Runs one command with operands from g_src/g_dst; optionally stalls the first result word.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] len, input int stall);
    int n, k, r, cyc, stall_left, done_cyc, exp_cyc;
    bit got_done, seen_res, hs_o, hs_r;
    n = int'(len) + 1;
    ref_model(op, n);
    chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
    k = 0; r = 0; cyc = 0; done_cyc = -1; got_done = 0; seen_res = 0; stall_left = stall;
    while (!got_done && cyc < 300) begin
      opnd_valid = (k < n);
      opnd_src   = g_src[(k < 8) ? k : 7];
      opnd_dst   = g_dst[(k < 8) ? k : 7];
      res_ready  = 1'b1;
      if (res_valid) begin
        seen_res = 1;
        chk("res_data", 32'(res_data), 32'(exp_res[(r < 8) ? r : 7]));
        chk("res_last", 32'(res_last), 32'(r == n - 1));
        if (r == 0 && stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
          chk("stall_opnd_ready", 32'(opnd_ready), 32'd0);
        end
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
      hs_o = opnd_valid && opnd_ready;
      hs_r = res_valid && res_ready;
      @(posedge mclk); #1;
      cyc++;
      if (hs_o) k++;
      if (hs_r) r++;
    end
    opnd_valid = 1'b0;
    res_ready  = 1'b0;
    exp_cyc = (op == OP_CMP) ? 2*n : 3*n + stall;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
    chk("res_count", 32'(r), (op == OP_CMP) ? 32'd0 : 32'(n));
    chk("res_seen", 32'(seen_res), 32'(op != OP_CMP));
    chk("done_stat", 32'(done_stat), 32'(exp_stat));
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    $display("txn op=%0d len=%0d done_stat=%h expected=%h done_cycle=%0d", op, len, done_stat, exp_stat, done_cyc);
  endtask

  task automatic set_w(input int i, input logic [15:0] s, input logic [15:0] d);
    g_src[i] = s;
    g_dst[i] = d;
  endtask

  task automatic rand_bcd(output logic [15:0] w);
    for (int d = 0; d < 4; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
  endtask

  initial begin
    logic [1:0]  rop;
    logic [2:0]  rlen;
    logic [15:0] t;
    for (int i = 0; i < 8; i++) set_w(i, 16'h0000, 16'h0000);

    // Reset state
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_stat", 32'(done_stat), 32'd0);
    chk("rst_alu_src", 32'(alu_op_src), 32'd0);
    chk("rst_inst", 32'(alu_inst_alu), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    puc_rst_n = 1'b1;
    @(posedge mclk); #1;

    // 2-word ADD, zero wait
    set_w(0, 16'h0001, 16'h0001);
    set_w(1, 16'hFFFF, 16'hFFFF);
    run_cmd(OP_ADD, 3'd1, 0);
    chk("add2_stat_plan", 32'(done_stat), 32'h5);

    // 1-word SUB equal, then borrow
    set_w(0, 16'h0005, 16'h0005);
    run_cmd(OP_SUB, 3'd0, 0);
    chk("sub_eq_stat", 32'(done_stat), 32'h3);
    set_w(0, 16'h0006, 16'h0005);
    run_cmd(OP_SUB, 3'd0, 0);
    chk("sub_borrow_stat", 32'(done_stat), 32'h4);

    // 4-word DADD 9999... + 1
    for (int i = 0; i < 4; i++) set_w(i, (i == 0) ? 16'h0001 : 16'h0000, 16'h9999);
    run_cmd(OP_DADD, 3'd3, 0);
    chk("dadd_stat", 32'(done_stat[1:0]), 32'h3);

    // 8-word CMP equal
    for (int i = 0; i < 8; i++) begin
      t = 16'($urandom);
      set_w(i, t, t);
    end
    run_cmd(OP_CMP, 3'd7, 0);
    chk("cmp_stat", 32'(done_stat), 32'h3);

    // 2-word ADD with 5 stalled cycles on word 1
    set_w(0, 16'h1234, 16'hF000);
    set_w(1, 16'h8000, 16'h8001);
    run_cmd(OP_ADD, 3'd1, 5);

    // Abort coincident with the word-2 operand handshake
    set_w(0, 16'h1111, 16'h0101);
    set_w(1, 16'h2222, 16'h0202);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_len = 3'd1;
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
    opnd_valid = 1'b1; opnd_src = 16'h1111; opnd_dst = 16'h0101;
    @(posedge mclk); #1;
    opnd_valid = 1'b0;
    @(posedge mclk); #1;
    res_ready = 1'b1;
    chk("abort_res_valid_pre", 32'(res_valid), 32'd1);
    @(posedge mclk); #1;
    res_ready = 1'b0;
    opnd_valid = 1'b1; opnd_src = 16'h2222; opnd_dst = 16'h0202;
    abort = 1'b1;
    #1;
    chk("abort_opnd_ready", 32'(opnd_ready), 32'd0);
    @(posedge mclk); #1;
    abort = 1'b0;
    opnd_valid = 1'b0;
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_xfer", 32'(alu_op_src), 32'h1111);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(posedge mclk); #1;
    end
    $display("txn abort cmd_ready=%0d busy=%0d", cmd_ready, busy);

    // Reset mid-command
    set_w(0, 16'h0F0F, 16'h7777);
    cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_len = 3'd3;
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
    opnd_valid = 1'b1; opnd_src = 16'h0F0F; opnd_dst = 16'h7777;
    @(posedge mclk); #1;
    opnd_valid = 1'b0;
    chk("pre_rst_exec", 32'(alu_exec_cycle), 32'd1);
    puc_rst_n = 1'b0;
    #1;
    chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mrst_done_stat", 32'(done_stat), 32'd0);
    chk("mrst_alu_src", 32'(alu_op_src), 32'd0);
    chk("mrst_alu_dst", 32'(alu_op_dst), 32'd0);
    chk("mrst_exec", 32'(alu_exec_cycle), 32'd0);
    @(posedge mclk); #1;
    puc_rst_n = 1'b1;
    @(posedge mclk); #1;
    chk("mrst_no_done", 32'(done), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);
    $display("txn reset cmd_ready=%0d done_stat=%h", cmd_ready, done_stat);

    // Random commands
    for (int tn = 0; tn < 24; tn++) begin
      rop  = 2'($urandom_range(0, 3));
      rlen = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) begin
        if (rop == OP_DADD) begin
          rand_bcd(g_src[i]);
          rand_bcd(g_dst[i]);
        end else begin
          g_src[i] = 16'($urandom);
          g_dst[i] = ($urandom_range(0, 3) == 0) ? g_src[i] : 16'($urandom);
        end
      end
      run_cmd(rop, rlen, (tn % 5 == 0) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
